// File: rtl/ets_sweep_accumulator_pkg.sv
// Shared constants for the ETS sweep accumulator: FSM encodings, err bit
// positions and default widths.
package ets_pkg;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_CNT_W         = 32;
  localparam int DEF_PHASE_W       = 16;
  localparam int DEF_SHIFT_TIMEOUT = 4096;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCUM  = 3'd1;
  localparam logic [2:0] ST_EMIT   = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam int ERR_CFG = 0;
  localparam int ERR_TMO = 1;
endpackage

// File: rtl/ets_sweep_accumulator_if.sv
// AXI-Stream result port between the sweep accumulator and the CDC FIFO.
interface ets_sweep_accumulator_if;
  import ets_pkg::*;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ets_channel_counter.sv
// Per-channel comparator '1' counter; clear has priority over counting.
module ets_channel_counter
  import ets_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sample_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             sample,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n)                count <= '0;
    else if (clear)            count <= '0;
    else if (enable && sample) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/ets_sweep_accumulator.sv
// Multi-channel ETS sweep: per phase, count comparator hits per enabled
// channel, stream counts out, then request a clock phase step.
module ets_sweep_accumulator
  import ets_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int PHASE_W       = DEF_PHASE_W,
  parameter int SHIFT_TIMEOUT = DEF_SHIFT_TIMEOUT
) (
  input  logic                  sample_clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     cmp_data,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [CNT_W-1:0]      avg_count,
  input  logic [PHASE_W-1:0]    num_phases,
  input  logic                  start,
  input  logic                  abort,
  output logic                  shift,
  input  logic                  shift_done,
  ets_sweep_accumulator_if.master m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = $clog2(SHIFT_TIMEOUT + 1);

  logic [2:0]                   state;
  logic [NUM_CH-1:0]            cmp_q, mask_q, cnt_en;
  logic                         start_q, abort_pend;
  logic [CNT_W-1:0]             avg_q, win_cnt;
  logic [PHASE_W-1:0]           np_q, phase;
  logic [TMO_W-1:0]             tmo_cnt;
  logic [CH_W-1:0]              emit_idx, first_ch, next_ch;
  logic                         has_next, cnt_clr;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [31:0]                  tdata_w;

  wire start_edge = start & ~start_q;
  wire hs         = m_axis.tvalid & m_axis.tready;
  wire last_phase = (phase == np_q - PHASE_W'(1));
  wire cfg_bad    = (avg_count == '0) || (num_phases == '0) || (ch_mask == '0);

  // Downward scan leaves the lowest matching index as the winner.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask_q[c]) first_ch = CH_W'(c);
      if (mask_q[c] && (CH_W'(c) > emit_idx)) begin
        next_ch  = CH_W'(c);
        has_next = 1'b1;
      end
    end
  end

  assign cnt_clr = ((state == ST_IDLE) && start_edge) ||
                   ((state == ST_WAIT) && !abort && shift_done);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cnt_en[c] = (state == ST_ACCUM) && mask_q[c];
    ets_channel_counter #(.CNT_W(CNT_W)) u_cnt (
      .sample_clk (sample_clk),
      .rst_n      (rst_n),
      .clear      (cnt_clr),
      .enable     (cnt_en[c]),
      .sample     (cmp_q[c]),
      .count      (cnt[c])
    );
  end

  always_comb begin
    tdata_w = '0;
    if (state == ST_EMIT) tdata_w[CNT_W-1:0] = cnt[emit_idx];
  end

  assign m_axis.tdata  = tdata_w;
  assign m_axis.tvalid = (state == ST_EMIT);
  assign m_axis.tlast  = (state == ST_EMIT) && !has_next && last_phase;
  assign busy          = (state != ST_IDLE);
  assign shift         = (state == ST_SHIFT);

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmp_q      <= '0;
      start_q    <= 1'b0;
      mask_q     <= '0;
      avg_q      <= '0;
      np_q       <= '0;
      phase      <= '0;
      win_cnt    <= '0;
      tmo_cnt    <= '0;
      emit_idx   <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      err        <= '0;
    end else begin
      start_q <= start;
      cmp_q   <= cmp_data;
      done    <= 1'b0;
      case (state)
        ST_IDLE: if (start_edge) begin
          mask_q     <= ch_mask;
          avg_q      <= avg_count;
          np_q       <= num_phases;
          err        <= '0;
          phase      <= '0;
          win_cnt    <= '0;
          abort_pend <= 1'b0;
          if (cfg_bad) begin
            err[ERR_CFG] <= 1'b1;
            done         <= 1'b1;
          end else begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (abort) state <= ST_IDLE;
          else if (win_cnt == avg_q - CNT_W'(1)) begin
            state    <= ST_EMIT;
            emit_idx <= first_ch;
            win_cnt  <= '0;
          end else begin
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        // A pending beat must complete before an abort takes effect.
        ST_EMIT: begin
          if (abort) abort_pend <= 1'b1;
          if (hs) begin
            if (abort || abort_pend) state <= ST_IDLE;
            else if (has_next)       emit_idx <= next_ch;
            else if (last_phase) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          tmo_cnt <= '0;
          state   <= abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) state <= ST_IDLE;
          else if (shift_done) begin
            phase   <= phase + PHASE_W'(1);
            win_cnt <= '0;
            state   <= ST_ACCUM;
          end else if (tmo_cnt == TMO_W'(SHIFT_TIMEOUT - 1)) begin
            err[ERR_TMO] <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ets_sweep_accumulator.sv
// Table-driven bench with a beat scoreboard for ets_sweep_accumulator.
module tb_ets_sweep_accumulator;
  import ets_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;
  localparam int TMO = 16;

  logic           sample_clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] cmp_data, ch_mask;
  logic [CW-1:0]  avg_count;
  logic [PW-1:0]  num_phases;
  logic           start, abort, shift, shift_done, busy, done, tready;
  logic [1:0]     err;

  ets_sweep_accumulator_if m_axis();
  assign m_axis.tready = tready;

  ets_sweep_accumulator #(.NUM_CH(NCH), .CNT_W(CW), .PHASE_W(PW), .SHIFT_TIMEOUT(TMO)) dut (
    .sample_clk (sample_clk),
    .rst_n      (rst_n),
    .cmp_data   (cmp_data),
    .ch_mask    (ch_mask),
    .avg_count  (avg_count),
    .num_phases (num_phases),
    .start      (start),
    .abort      (abort),
    .shift      (shift),
    .shift_done (shift_done),
    .m_axis     (m_axis),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]       mask;
    logic [31:0]      avg;
    logic [15:0]      phases;
    logic [3:0]       cmp;
    logic [3:0]       tog;
    logic [3:0][31:0] val;
    int               beats;
    int               shifts;
    logic [1:0]       err;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vt[8];

  int checks = 0, errors = 0, cyc_n = 0;
  int n_done, n_shift, n_tlast, n_beats, first_valid, last_hs, done_cyc, shift_cyc, err_cyc;
  logic busy_seen, prev_stall, prev_last;
  logic [31:0] prev_data;
  int sd_lat = 5, sd_cnt = 0, stall_at = -1, stall_left = 0;
  logic [3:0] tog_mask = '0;
  logic manual_rdy = 1'b0;

  function automatic vec_t mkv(input logic [3:0] mask, input logic [31:0] avg,
                               input logic [15:0] ph, input logic [3:0] cmp, input logic [3:0] tog,
                               input logic [31:0] v3, v2, v1, v0,
                               input int beats, shifts, input logic [1:0] e);
    vec_t v;
    v.mask = mask; v.avg = avg; v.phases = ph; v.cmp = cmp; v.tog = tog;
    v.val = {v3, v2, v1, v0};
    v.beats = beats; v.shifts = shifts; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic monitor();
    beat_t b;
    cyc_n++;
    if (busy) busy_seen = 1'b1;
    if (done) begin n_done++; done_cyc = cyc_n; end
    if (shift) begin
      n_shift++;
      shift_cyc = cyc_n;
      if (sd_lat > 0) sd_cnt = sd_lat;
    end
    if (err[1] && err_cyc < 0) err_cyc = cyc_n;
    if (prev_stall) begin
      chk("hold_tvalid", m_axis.tvalid, 1);
      chk("hold_tdata", m_axis.tdata, prev_data);
      chk("hold_tlast", m_axis.tlast, prev_last);
    end
    if (m_axis.tvalid && first_valid < 0) first_valid = cyc_n;
    if (m_axis.tvalid && tready) begin
      n_beats++;
      last_hs = cyc_n;
      if (m_axis.tlast) n_tlast++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got tdata %0d, expected no beat", m_axis.tdata);
      end else begin
        b = exp_q.pop_front();
        chk("tdata", m_axis.tdata, b.data);
        chk("tlast", m_axis.tlast, b.last);
      end
    end
    prev_stall = m_axis.tvalid && !tready;
    prev_data  = m_axis.tdata;
    prev_last  = m_axis.tlast;
  endtask

  // Sample at negedge, then advance to just past the next active edge and
  // update the shift_done responder, toggling stimulus and ready pattern.
  task automatic cyc();
    @(negedge sample_clk);
    monitor();
    @(posedge sample_clk);
    #1;
    shift_done = 1'b0;
    if (sd_cnt > 0) begin
      sd_cnt--;
      if (sd_cnt == 0) shift_done = 1'b1;
    end
    cmp_data = cmp_data ^ tog_mask;
    if (!manual_rdy) begin
      if (stall_left > 0 && n_beats == stall_at) begin
        tready = 1'b0;
        stall_left--;
      end else begin
        tready = 1'b1;
      end
    end
  endtask

  task automatic reset_mon();
    n_done = 0; n_shift = 0; n_tlast = 0; n_beats = 0;
    first_valid = -1; last_hs = -1; done_cyc = -1; shift_cyc = -1; err_cyc = -1;
    busy_seen = 1'b0; prev_stall = 1'b0;
    exp_q.delete();
  endtask

  task automatic setup(input logic [3:0] mask, input logic [31:0] avg, input logic [15:0] ph,
                       input logic [3:0] cmp, input logic [3:0] tog);
    reset_mon();
    ch_mask = mask; avg_count = avg; num_phases = ph; cmp_data = cmp; tog_mask = tog;
    cyc(); cyc();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int hi, s0;
    setup(v.mask, v.avg, v.phases, v.cmp, v.tog);
    hi = 0;
    for (int c = 0; c < NCH; c++) if (v.mask[c]) hi = c;
    if (v.err == 2'b00)
      for (int p = 0; p < int'(v.phases); p++)
        for (int c = 0; c < NCH; c++)
          if (v.mask[c]) push_beat(v.val[c], (p == int'(v.phases) - 1) && (c == hi));
    start = 1'b1;
    cyc();
    s0 = cyc_n;
    start = 1'b0;
    for (int k = 0; k < 600 && n_done == 0 && err_cyc < 0; k++) cyc();
    for (int k = 0; k < 3; k++) cyc();
    $display("vector %s", tag);
    chk("done_count", n_done, 1);
    chk("err", err, v.err);
    chk("beats_pending", exp_q.size(), 0);
    chk("beat_count", n_beats, v.beats);
    chk("shift_count", n_shift, v.shifts);
    chk("tlast_count", n_tlast, (v.beats > 0) ? 1 : 0);
    if (v.err == 2'b00) begin
      chk("first_valid_latency", first_valid - s0, v.avg + 1);
      chk("done_after_last_beat", done_cyc - last_hs, 1);
    end else begin
      chk("busy_on_bad_cfg", busy_seen, 0);
    end
  endtask

  initial begin
    vec_t sv;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; shift_done = 1'b0; tready = 1'b1;
    cmp_data = '0; ch_mask = '0; avg_count = '0; num_phases = '0;
    reset_mon();
    #12;
    chk("rst_shift", shift, 0);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge sample_clk); #1;
    rst_n = 1'b1;
    cyc();

    vt[0] = mkv(4'b1011,  8, 3, 4'b1111, 4'b0000, 8, 8, 8, 8, 9, 2, 2'b00);
    vt[1] = mkv(4'b0010, 10, 1, 4'b0000, 4'b0010, 0, 0, 5, 0, 1, 0, 2'b00);
    vt[2] = mkv(4'b0101,  5, 2, 4'b0100, 4'b0000, 0, 5, 0, 0, 4, 1, 2'b00);
    vt[3] = mkv(4'b1111,  3, 1, 4'b1010, 4'b0000, 3, 0, 3, 0, 4, 0, 2'b00);
    vt[4] = mkv(4'b0001,  0, 1, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b01);
    vt[5] = mkv(4'b0001,  4, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b01);
    vt[6] = mkv(4'b0000,  4, 1, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b01);
    vt[7] = mkv(4'b1000,  1, 2, 4'b1000, 4'b0000, 1, 0, 0, 0, 2, 1, 2'b00);
    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("%0d", i));

    // ready stall of 3 cycles on the second beat
    stall_at = 1; stall_left = 3;
    sv = mkv(4'b1111, 4, 1, 4'b1111, 4'b0000, 4, 4, 4, 4, 4, 0, 2'b00);
    run_vec(sv, "stall");
    stall_at = -1; stall_left = 0;

    // shift_done never returns
    sd_lat = 0;
    setup(4'b0001, 2, 2, 4'b0001, 4'b0000);
    push_beat(2, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 100 && err_cyc < 0; k++) cyc();
    for (int k = 0; k < 3; k++) cyc();
    chk("tmo_err", err, 2'b10);
    chk("tmo_shift_count", n_shift, 1);
    chk("tmo_done_count", n_done, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_beats_pending", exp_q.size(), 0);
    chk("tmo_distance_ok", ((err_cyc - shift_cyc) == 16) || ((err_cyc - shift_cyc) == 17), 1);
    sd_lat = 5;

    // abort during EMIT with ready held low
    manual_rdy = 1'b1; tready = 1'b0;
    setup(4'b0011, 2, 2, 4'b0011, 4'b0000);
    push_beat(2, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 50 && !m_axis.tvalid; k++) cyc();
    abort = 1'b1;
    cyc(); cyc(); cyc();
    tready = 1'b1;
    cyc();
    chk("abort_emit_busy", busy, 0);
    abort = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("abort_emit_beats", n_beats, 1);
    chk("abort_emit_pending", exp_q.size(), 0);
    chk("abort_emit_tlast", n_tlast, 0);
    chk("abort_emit_done", n_done, 0);
    manual_rdy = 1'b0;

    // abort during ACCUM
    setup(4'b0001, 20, 1, 4'b0001, 4'b0000);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    abort = 1'b1;
    cyc();
    chk("abort_accum_busy", busy, 0);
    abort = 1'b0;
    for (int k = 0; k < 25; k++) cyc();
    chk("abort_accum_beats", n_beats, 0);
    chk("abort_accum_done", n_done, 0);

    // start held high across a complete sweep must not retrigger
    setup(4'b0001, 3, 1, 4'b0001, 4'b0000);
    push_beat(3, 1'b1);
    start = 1'b1;
    for (int k = 0; k < 50 && n_done == 0; k++) cyc();
    busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("held_start_busy", busy_seen, 0);
    chk("held_start_beats", n_beats, 1);
    chk("held_start_done", n_done, 1);
    start = 1'b0;
    cyc();

    // asynchronous reset in the middle of ACCUM
    setup(4'b1111, 20, 2, 4'b1111, 4'b0000);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tvalid", m_axis.tvalid, 0);
    chk("mid_rst_tdata", m_axis.tdata, 0);
    chk("mid_rst_tlast", m_axis.tlast, 0);
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) cyc();
    chk("post_rst_beats", n_beats, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
